// File: rtl/router_ctrl_fsm_n.sv
// router_ctrl_fsm_n
// Controller FSM for a 1xN packet router. It decodes the header address,
// sequences header/payload/parity loading into the selected output FIFO,
// stalls on FIFO-full, bounds the wait for a busy FIFO to drain, silently
// drops packets with an out-of-range address and honours per-channel soft
// reset.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   pkt_valid      packet byte valid from source
//   data_in        header address bits, sampled in DECODE_ADDRESS
//   parity_done    parity byte captured by datapath
//   low_pkt_valid  pkt_valid went low during full handling
//   fifo_full      per-channel FIFO full
//   fifo_empty     per-channel FIFO empty
//   soft_reset     per-channel soft reset
//   detect_add .. rst_int_reg, drop_state   one-hot state decodes
//   write_enb_reg  datapath write enable
//   busy           stall request to source
//   ch_sel         one-hot selected channel (0 in DA and DROP)
//   timeout_err    one-cycle pulse on the first DROP cycle after a wait timeout
module router_ctrl_fsm_n #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 2,
    parameter int WAIT_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic [NUM_CH-1:0] fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              drop_state,
    output logic [NUM_CH-1:0] ch_sel,
    output logic              timeout_err
);

    localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    typedef enum logic [3:0] {
        DA, LFD, WTE, LD, FFS, LAF, LP, CPE, DROP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;

    logic [NUM_CH-1:0]   a_oh, sel_oh;
    logic                addr_valid, empty_a, empty_sel, full_sel, soft_sel;

    // One-hot decodes; an out-of-range address yields an all-zero vector,
    // which doubles as the validity check and avoids out-of-range indexing.
    always_comb begin
        a_oh   = '0;
        sel_oh = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            a_oh[i]   = (data_in == ADDR_W'(i));
            sel_oh[i] = (sel_q == ADDR_W'(i));
        end
    end

    assign addr_valid = |a_oh;
    assign empty_a    = |(fifo_empty & a_oh);
    assign empty_sel  = |(fifo_empty & sel_oh);
    assign full_sel   = |(fifo_full & sel_oh);
    assign soft_sel   = |(soft_reset & sel_oh);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        case (state_q)
            DA: begin
                if (pkt_valid) begin
                    if (addr_valid) begin
                        sel_d   = data_in;
                        state_d = empty_a ? LFD : WTE;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            LFD: state_d = LD;
            WTE: begin
                // Empty is checked first so a drain on the last wait cycle still loads.
                if (empty_sel) begin
                    state_d = LFD;
                end else if ((WAIT_MAX != 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = DROP;
                    timeout_d = 1'b1;
                end
            end
            LD: begin
                if (full_sel)       state_d = FFS;
                else if (!pkt_valid) state_d = LP;
            end
            FFS: if (!full_sel) state_d = LAF;
            LAF: begin
                if (parity_done)        state_d = DA;
                else if (low_pkt_valid) state_d = LP;
                else                    state_d = LD;
            end
            LP:   state_d = CPE;
            CPE:  state_d = full_sel ? FFS : DA;
            DROP: if (!pkt_valid) state_d = DA;
            default: state_d = DA;
        endcase

        // Soft reset of the selected channel overrides every transition,
        // including a pending timeout.
        if (soft_sel && (state_q != DA) && (state_q != DROP)) begin
            state_d   = DA;
            timeout_d = 1'b0;
        end
    end

    // Counter rests at zero outside WTE, so it is zero on entry; saturates.
    always_comb begin
        cnt_d = '0;
        if (state_q == WTE) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DA;
            sel_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign detect_add    = (state_q == DA);
    assign lfd_state     = (state_q == LFD);
    assign ld_state      = (state_q == LD);
    assign laf_state     = (state_q == LAF);
    assign full_state    = (state_q == FFS);
    assign rst_int_reg   = (state_q == CPE);
    assign drop_state    = (state_q == DROP);
    assign write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
    assign busy          = (state_q == LFD) || (state_q == WTE) || (state_q == FFS) ||
                           (state_q == LAF) || (state_q == LP)  || (state_q == CPE);
    assign ch_sel        = ((state_q == DA) || (state_q == DROP)) ? '0 : sel_oh;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_router_ctrl_fsm_n.sv
// tb_router_ctrl_fsm_n
// Directed self-checking bench for router_ctrl_fsm_n with default parameters
// (NUM_CH=3, ADDR_W=2, WAIT_MAX=16). Each cycle's outputs are compared as one
// vector {decodes, write_enb_reg, busy, ch_sel, timeout_err} against
// hand-derived constants.
module tb_router_ctrl_fsm_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy, drop_state, timeout_err;
    logic [2:0] ch_sel;

    int n_chk  = 0;
    int n_fail = 0;

    // Bit order: da lfd ld laf full rst_int drop wen busy
    localparam logic [8:0] O_DA   = 9'b100000000;
    localparam logic [8:0] O_LFD  = 9'b010000001;
    localparam logic [8:0] O_LD   = 9'b001000010;
    localparam logic [8:0] O_LAF  = 9'b000100011;
    localparam logic [8:0] O_FFS  = 9'b000010001;
    localparam logic [8:0] O_CPE  = 9'b000001001;
    localparam logic [8:0] O_DROP = 9'b000000100;
    localparam logic [8:0] O_LP   = 9'b000000011;
    localparam logic [8:0] O_WTE  = 9'b000000001;

    logic [12:0] mon;
    logic [12:0] want;
    assign mon = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                  drop_state, write_enb_reg, busy, ch_sel, timeout_err};

    router_ctrl_fsm_n #(.NUM_CH(3), .ADDR_W(2), .WAIT_MAX(16)) dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .drop_state(drop_state),
        .ch_sel(ch_sel), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs changed here hold until the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
        low_pkt_valid = 1'b0; fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
        tick(); tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL reset_state: got %b expected %b", mon, want); end
        reset = 1'b0;
    endtask

    task automatic test_normal_flow();
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b111;
        tick();
        want = {O_LFD, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL flow_lfd: got %b expected %b", mon, want); end
        tick();
        want = {O_LD, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL flow_ld: got %b expected %b", mon, want); end
        fifo_full = 3'b100;
        for (int i = 0; i < 3; i++) begin
            tick();
            want = {O_FFS, 3'b100, 1'b0}; n_chk++;
            if (mon !== want) begin n_fail++; $display("FAIL flow_ffs%0d: got %b expected %b", i, mon, want); end
        end
        fifo_full = 3'b000;
        tick();
        want = {O_LAF, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL flow_laf: got %b expected %b", mon, want); end
        tick();
        want = {O_LD, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL flow_laf_ld: got %b expected %b", mon, want); end
    endtask

    task automatic test_parity_end();
        pkt_valid = 1'b0;
        tick();
        want = {O_LP, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL end_lp: got %b expected %b", mon, want); end
        tick();
        want = {O_CPE, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL end_cpe: got %b expected %b", mon, want); end
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL end_da: got %b expected %b", mon, want); end
    endtask

    task automatic test_timeout();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
        tick();
        want = {O_WTE, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL to_wte_entry: got %b expected %b", mon, want); end
        for (int i = 1; i < 16; i++) begin
            tick();
            want = {O_WTE, 3'b010, 1'b0}; n_chk++;
            if (mon !== want) begin n_fail++; $display("FAIL to_wte%0d: got %b expected %b", i, mon, want); end
        end
        tick();
        want = {O_DROP, 3'b000, 1'b1}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL to_drop_pulse: got %b expected %b", mon, want); end
        tick();
        want = {O_DROP, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL to_drop_hold: got %b expected %b", mon, want); end
        pkt_valid = 1'b0;
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL to_da: got %b expected %b", mon, want); end
    endtask

    task automatic test_empty_wins_and_full_priority();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
        tick();
        for (int i = 1; i < 16; i++) tick();
        want = {O_WTE, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL ew_last_wte: got %b expected %b", mon, want); end
        fifo_empty = 3'b111;
        tick();
        want = {O_LFD, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL ew_lfd: got %b expected %b", mon, want); end
        tick();
        want = {O_LD, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL ew_ld: got %b expected %b", mon, want); end
        fifo_full = 3'b010; pkt_valid = 1'b0;
        tick();
        want = {O_FFS, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL fp_ffs: got %b expected %b", mon, want); end
        fifo_full = 3'b000; low_pkt_valid = 1'b1;
        tick();
        want = {O_LAF, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL fp_laf: got %b expected %b", mon, want); end
        tick();
        want = {O_LP, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL fp_lp: got %b expected %b", mon, want); end
        low_pkt_valid = 1'b0;
        tick();
        want = {O_CPE, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL fp_cpe: got %b expected %b", mon, want); end
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL fp_da: got %b expected %b", mon, want); end
    endtask

    task automatic test_invalid_addr();
        pkt_valid = 1'b1; data_in = 2'd3; fifo_empty = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            want = {O_DROP, 3'b000, 1'b0}; n_chk++;
            if (mon !== want) begin n_fail++; $display("FAIL inv_drop%0d: got %b expected %b", i, mon, want); end
        end
        pkt_valid = 1'b0;
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL inv_da: got %b expected %b", mon, want); end
    endtask

    task automatic test_soft_reset_ffs();
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b111;
        tick(); tick();
        want = {O_LD, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL sr_ld: got %b expected %b", mon, want); end
        soft_reset = 3'b001;
        tick();
        want = {O_LD, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL sr_other_ch: got %b expected %b", mon, want); end
        soft_reset = 3'b000; fifo_full = 3'b100;
        tick();
        want = {O_FFS, 3'b100, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL sr_ffs: got %b expected %b", mon, want); end
        soft_reset = 3'b100; pkt_valid = 1'b0;
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL sr_ffs_da: got %b expected %b", mon, want); end
        soft_reset = 3'b000; fifo_full = 3'b000;
        tick();
    endtask

    task automatic test_soft_reset_wte();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
        tick(); tick();
        want = {O_WTE, 3'b010, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL srw_wte: got %b expected %b", mon, want); end
        soft_reset = 3'b010; pkt_valid = 1'b0;
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL srw_da: got %b expected %b", mon, want); end
        soft_reset = 3'b000; pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b111;
        tick();
        want = {O_LFD, 3'b001, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL srw_next_lfd: got %b expected %b", mon, want); end
        tick();
        want = {O_LD, 3'b001, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL srw_next_ld: got %b expected %b", mon, want); end
        pkt_valid = 1'b0;
        tick(); tick();
        want = {O_CPE, 3'b001, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL srw_next_cpe: got %b expected %b", mon, want); end
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL srw_next_da: got %b expected %b", mon, want); end
    endtask

    task automatic test_reset_mid_packet();
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b111;
        tick(); tick();
        reset = 1'b1;
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL midrst_da: got %b expected %b", mon, want); end
        reset = 1'b0; pkt_valid = 1'b0;
        tick();
        want = {O_DA, 3'b000, 1'b0}; n_chk++;
        if (mon !== want) begin n_fail++; $display("FAIL midrst_idle: got %b expected %b", mon, want); end
    endtask

    initial begin
        test_reset();
        test_normal_flow();
        test_parity_end();
        test_timeout();
        test_empty_wins_and_full_priority();
        test_invalid_addr();
        test_soft_reset_ffs();
        test_soft_reset_wte();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
